// File: rtl/controller.sv
// -----------------------------------------------------------------------------
// controller
//
// Multi-cycle control FSM for a small ARM-like datapath. Each instruction goes
// through FETCH -> FETCH_WAIT -> DECODE and then, depending on its class and
// condition code, EXECUTE / MEMORY / MEMORY_WAIT / WRITE_BACK before it
// returns to FETCH.
//
// All outputs are decoded from the current state and the latched instruction
// register (IR), so an asynchronous reset takes them back to their idle values
// straight away. No output depends combinationally on `instr`.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   instr[31:0]                word from instruction RAM, latched into IR
//   status[31:0]               datapath status; NZCV = status[31:28]
//   A_addr/B_addr/shift_addr   register-file read addresses
//   en_A/en_B/en_S/en_status   datapath register enables
//   sel_A_in/sel_B_in/
//   sel_shift_in               read-source selects (00 regfile, 01 PC)
//   sel_A/sel_B/sel_shift/
//   sel_post_shift             operand selects
//   shift_op, shift_imme       shifter operation and immediate amount
//   imme_data, ALU_op          immediate operand and ALU operation
//   w_addr1/w_addr2,
//   w_en1/w_en2,
//   forward_w_data             register-file write controls
//   pc_en, pc_sel              PC load (pc_sel 0 = PC+4, 1 = datapath_out)
//   ir_en, addr_en, ram_rd,
//   ram_w_en, waiting          fetch / memory handshake controls
// -----------------------------------------------------------------------------
module controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] status,
  output logic [3:0]  A_addr,
  output logic [3:0]  B_addr,
  output logic [3:0]  shift_addr,
  output logic        en_A,
  output logic        en_B,
  output logic        en_S,
  output logic        en_status,
  output logic [1:0]  sel_A_in,
  output logic [1:0]  sel_B_in,
  output logic [1:0]  sel_shift_in,
  output logic        sel_A,
  output logic        sel_B,
  output logic        sel_shift,
  output logic        sel_post_shift,
  output logic [1:0]  shift_op,
  output logic [31:0] shift_imme,
  output logic [31:0] imme_data,
  output logic [2:0]  ALU_op,
  output logic [3:0]  w_addr1,
  output logic [3:0]  w_addr2,
  output logic        w_en1,
  output logic        w_en2,
  output logic        forward_w_data,
  output logic        pc_en,
  output logic        pc_sel,
  output logic        ir_en,
  output logic        addr_en,
  output logic        ram_rd,
  output logic        ram_w_en,
  output logic        waiting
);

  typedef enum logic [2:0] {
    FETCH       = 3'd0,
    FETCH_WAIT  = 3'd1,
    DECODE      = 3'd2,
    EXECUTE     = 3'd3,
    MEMORY      = 3'd4,
    MEMORY_WAIT = 3'd5,
    WRITE_BACK  = 3'd6
  } state_t;

  state_t      state;
  logic [31:0] ir;

  // ARM condition-code evaluation against NZCV.
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic pass;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'b0000: pass = z;
      4'b0001: pass = ~z;
      4'b0010: pass = c;
      4'b0011: pass = ~c;
      4'b0100: pass = n;
      4'b0101: pass = ~n;
      4'b0110: pass = v;
      4'b0111: pass = ~v;
      4'b1000: pass = c & ~z;
      4'b1001: pass = ~c | z;
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = ~z & (n == v);
      4'b1101: pass = z | (n != v);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

  // Data-processing opcodes this controller knows how to sequence.
  function automatic logic dp_supported(input logic [3:0] opcode);
    logic ok;
    case (opcode)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b1010, 4'b1100, 4'b1101: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Data-processing opcode to ALU operation.
  function automatic logic [2:0] dp_alu_op(input logic [3:0] opcode);
    logic [2:0] op;
    case (opcode)
      4'b0000: op = 3'b010;  // AND
      4'b0001: op = 3'b100;  // EOR
      4'b0010: op = 3'b001;  // SUB
      4'b0100: op = 3'b000;  // ADD
      4'b1010: op = 3'b001;  // CMP
      4'b1100: op = 3'b011;  // ORR
      4'b1101: op = 3'b000;  // MOV (A operand forced to zero by sel_A)
      default: op = 3'b000;
    endcase
    return op;
  endfunction

  // Instruction-class decode from the latched IR.
  logic [3:0] opcode;
  logic       is_dp;
  logic       is_mem;
  logic       is_br;
  logic       is_cmp;
  logic       is_mov;
  logic       is_load;
  logic       is_imm;
  logic       reg_shift;
  logic       supported;
  logic       cond_pass;
  logic       unused_status;

  assign opcode    = ir[24:21];
  assign is_dp     = (ir[27:26] == 2'b00);
  assign is_mem    = (ir[27:25] == 3'b010);
  assign is_br     = (ir[27:25] == 3'b101);
  assign is_cmp    = (opcode == 4'b1010);
  assign is_mov    = (opcode == 4'b1101);
  assign is_load   = ir[20];
  assign is_imm    = ir[25];
  assign reg_shift = is_dp & ~is_imm & ir[4];
  assign supported = (is_dp & dp_supported(opcode)) | is_mem | is_br;
  assign cond_pass = cond_check(ir[31:28], status[31:28]);
  assign unused_status = ^status[27:0];

  // State sequencing and IR capture; reset returns to FETCH with an empty IR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      ir    <= 32'd0;
    end else begin
      case (state)
        FETCH: begin
          state <= FETCH_WAIT;
        end
        FETCH_WAIT: begin
          ir    <= instr;
          state <= DECODE;
        end
        DECODE: begin
          if (cond_pass && supported) begin
            state <= EXECUTE;
          end else begin
            state <= FETCH;
          end
        end
        EXECUTE: begin
          if (is_dp) begin
            state <= is_cmp ? FETCH : WRITE_BACK;
          end else if (is_mem) begin
            state <= MEMORY;
          end else begin
            state <= FETCH;
          end
        end
        MEMORY: begin
          state <= MEMORY_WAIT;
        end
        MEMORY_WAIT: begin
          state <= is_load ? WRITE_BACK : FETCH;
        end
        WRITE_BACK: begin
          state <= FETCH;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  // Moore output decode from state and IR.
  always_comb begin
    A_addr         = 4'd0;
    B_addr         = 4'd0;
    shift_addr     = 4'd0;
    en_A           = 1'b0;
    en_B           = 1'b0;
    en_S           = 1'b0;
    en_status      = 1'b0;
    sel_A_in       = 2'b00;
    sel_B_in       = 2'b00;
    sel_shift_in   = 2'b00;
    sel_A          = 1'b0;
    sel_B          = 1'b0;
    sel_shift      = 1'b0;
    sel_post_shift = 1'b0;
    shift_op       = 2'b00;
    shift_imme     = 32'd0;
    imme_data      = 32'd0;
    ALU_op         = 3'b000;
    w_addr1        = 4'd0;
    w_addr2        = 4'd0;
    w_en1          = 1'b0;
    w_en2          = 1'b0;
    forward_w_data = 1'b0;
    pc_en          = 1'b0;
    pc_sel         = 1'b0;
    ir_en          = 1'b0;
    addr_en        = 1'b0;
    ram_rd         = 1'b0;
    ram_w_en       = 1'b0;
    waiting        = 1'b0;

    case (state)
      FETCH: begin
        ram_rd  = 1'b1;
        waiting = 1'b1;
      end

      FETCH_WAIT: begin
        ir_en   = 1'b1;
        pc_en   = 1'b1;
        pc_sel  = 1'b0;
        waiting = 1'b1;
      end

      DECODE: begin
        en_A   = 1'b1;
        en_B   = 1'b1;
        en_S   = 1'b1;
        A_addr = ir[19:16];
        B_addr = ir[3:0];
        if (reg_shift) begin
          shift_addr = ir[11:8];
          sel_shift  = 1'b1;
        end else begin
          shift_imme = {27'd0, ir[11:7]};
        end
        // Branches compute PC + offset, so the A operand comes from the PC.
        if (is_br) begin
          sel_A_in = 2'b01;
        end else begin
          sel_A_in = 2'b00;
        end
      end

      EXECUTE, WRITE_BACK: begin
        if (is_dp) begin
          ALU_op   = dp_alu_op(opcode);
          shift_op = ir[6:5];
          sel_A    = is_mov;
          if (is_imm) begin
            sel_B     = 1'b1;
            imme_data = {24'd0, ir[7:0]};
          end else begin
            sel_B     = 1'b0;
          end
          if (state == EXECUTE) begin
            en_status = ir[20] | is_cmp;
          end else begin
            w_addr2 = ir[15:12];
            w_en2   = 1'b1;
          end
        end else if (is_mem && (state == EXECUTE)) begin
          sel_B     = 1'b1;
          imme_data = {20'd0, ir[11:0]};
          ALU_op    = ir[23] ? 3'b000 : 3'b001;
          addr_en   = 1'b1;
        end else if (is_mem) begin
          // LDR write-back of the loaded word.
          w_addr1        = ir[15:12];
          w_en1          = 1'b1;
          forward_w_data = 1'b1;
        end else if (is_br && (state == EXECUTE)) begin
          sel_B     = 1'b1;
          imme_data = {{6{ir[23]}}, ir[23:0], 2'b00};
          ALU_op    = 3'b000;
          pc_en     = 1'b1;
          pc_sel    = 1'b1;
        end else begin
          ALU_op = 3'b000;
        end
      end

      MEMORY: begin
        if (is_load) begin
          ram_rd = 1'b1;
        end else begin
          // STR: read the source register and pass it through the ALU.
          B_addr   = ir[15:12];
          en_B     = 1'b1;
          sel_A    = 1'b1;
          ALU_op   = 3'b000;
          ram_w_en = 1'b1;
        end
      end

      MEMORY_WAIT: begin
        waiting = 1'b0;
      end

      default: begin
        waiting = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_controller.sv
// -----------------------------------------------------------------------------
// tb_controller
//
// Directed bench for the controller FSM: walks a set of instruction words
// through the FSM and compares state and control outputs against hand-derived
// values at each negative clock edge.
// -----------------------------------------------------------------------------
module tb_controller;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] status;
  logic [3:0]  A_addr, B_addr, shift_addr;
  logic        en_A, en_B, en_S, en_status;
  logic [1:0]  sel_A_in, sel_B_in, sel_shift_in;
  logic        sel_A, sel_B, sel_shift, sel_post_shift;
  logic [1:0]  shift_op;
  logic [31:0] shift_imme, imme_data;
  logic [2:0]  ALU_op;
  logic [3:0]  w_addr1, w_addr2;
  logic        w_en1, w_en2, forward_w_data;
  logic        pc_en, pc_sel, ir_en, addr_en, ram_rd, ram_w_en, waiting;

  localparam logic [2:0] S_FETCH       = 3'd0;
  localparam logic [2:0] S_FETCH_WAIT  = 3'd1;
  localparam logic [2:0] S_DECODE      = 3'd2;
  localparam logic [2:0] S_EXECUTE     = 3'd3;
  localparam logic [2:0] S_MEMORY      = 3'd4;
  localparam logic [2:0] S_MEMORY_WAIT = 3'd5;
  localparam logic [2:0] S_WRITE_BACK  = 3'd6;

  int n_checks;
  int n_fail;

  logic [2:0] st;

  controller dut (
    .clk            (clk),
    .rst            (rst),
    .instr          (instr),
    .status         (status),
    .A_addr         (A_addr),
    .B_addr         (B_addr),
    .shift_addr     (shift_addr),
    .en_A           (en_A),
    .en_B           (en_B),
    .en_S           (en_S),
    .en_status      (en_status),
    .sel_A_in       (sel_A_in),
    .sel_B_in       (sel_B_in),
    .sel_shift_in   (sel_shift_in),
    .sel_A          (sel_A),
    .sel_B          (sel_B),
    .sel_shift      (sel_shift),
    .sel_post_shift (sel_post_shift),
    .shift_op       (shift_op),
    .shift_imme     (shift_imme),
    .imme_data      (imme_data),
    .ALU_op         (ALU_op),
    .w_addr1        (w_addr1),
    .w_addr2        (w_addr2),
    .w_en1          (w_en1),
    .w_en2          (w_en2),
    .forward_w_data (forward_w_data),
    .pc_en          (pc_en),
    .pc_sel         (pc_sel),
    .ir_en          (ir_en),
    .addr_en        (addr_en),
    .ram_rd         (ram_rd),
    .ram_w_en       (ram_w_en),
    .waiting        (waiting)
  );

  assign st = dut.state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a word in FETCH and advance to DECODE, checking the fetch states.
  task automatic begin_instr(input string tag, input logic [31:0] word, input logic [31:0] stat);
    instr  = word;
    status = stat;
    check_val({tag, "_fetch_state"}, {29'd0, st}, {29'd0, S_FETCH});
    check_val({tag, "_fetch_ram_rd"}, {31'd0, ram_rd}, 32'd1);
    step();
    check_val({tag, "_fw_state"}, {29'd0, st}, {29'd0, S_FETCH_WAIT});
    check_val({tag, "_fw_ctrl"}, {28'd0, ir_en, pc_en, pc_sel, waiting}, {28'd0, 4'b1101});
    step();
    check_val({tag, "_dec_state"}, {29'd0, st}, {29'd0, S_DECODE});
    check_val({tag, "_dec_en"}, {29'd0, en_A, en_B, en_S}, {29'd0, 3'b111});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    instr    = 32'd0;
    status   = 32'd0;
    repeat (2) @(negedge clk);

    // Reset state
    check_val("rst_state", {29'd0, st}, {29'd0, S_FETCH});
    check_val("rst_ir", dut.ir, 32'd0);
    check_val("rst_outs", {26'd0, ram_rd, waiting, pc_en, w_en1, w_en2, ir_en}, {26'd0, 6'b110000});
    rst = 1'b0;

    // ADD r2,r1,r2 : 5 cycles, write-back to r2
    begin_instr("add", 32'hE0812002, 32'd0);
    check_val("add_A_addr", {28'd0, A_addr}, 32'd1);
    check_val("add_B_addr", {28'd0, B_addr}, 32'd2);
    check_val("add_shift", {31'd0, sel_shift}, 32'd0);
    check_val("add_shimm", shift_imme, 32'd0);
    step();
    check_val("add_ex_state", {29'd0, st}, {29'd0, S_EXECUTE});
    check_val("add_ex_alu", {29'd0, ALU_op}, 32'd0);
    check_val("add_ex_status", {31'd0, en_status}, 32'd0);
    step();
    check_val("add_wb_state", {29'd0, st}, {29'd0, S_WRITE_BACK});
    check_val("add_wb_w", {26'd0, w_en2, w_en1, w_addr2}, {26'd0, 2'b10, 4'd2});
    step();

    // ADD with register-specified ASR: shift_addr = r3
    begin_instr("addrs", 32'hE0812352, 32'd0);
    check_val("addrs_shaddr", {27'd0, sel_shift, shift_addr}, {27'd0, 1'b1, 4'd3});
    step();
    check_val("addrs_shop", {30'd0, shift_op}, 32'd2);
    step();
    step();

    // CMP r0,#5 : 4 cycles, flags only
    begin_instr("cmp", 32'hE3500005, 32'd0);
    step();
    check_val("cmp_ex_state", {29'd0, st}, {29'd0, S_EXECUTE});
    check_val("cmp_ex_ctrl", {27'd0, en_status, sel_B, ALU_op}, {27'd0, 2'b11, 3'b001});
    check_val("cmp_imme", imme_data, 32'd5);
    check_val("cmp_no_wr", {30'd0, w_en1, w_en2}, 32'd0);
    step();
    // begin_instr of the next test confirms the return to FETCH

    // MOV r1,#15 : sel_A forces zero A operand, held through write-back
    begin_instr("mov", 32'hE3A0100F, 32'd0);
    step();
    check_val("mov_ex", {27'd0, sel_A, sel_B, ALU_op}, {27'd0, 2'b11, 3'b000});
    check_val("mov_imme", imme_data, 32'h0000000F);
    step();
    check_val("mov_wb", {26'd0, sel_A, w_en2, w_addr2}, {26'd0, 2'b11, 4'd1});
    step();

    // BEQ with Z = 0 : not taken
    begin_instr("beq0", 32'h0A000000, 32'd0);
    check_val("beq0_selain", {30'd0, sel_A_in}, 32'd1);
    check_val("beq0_dec_pc", {31'd0, pc_en}, 32'd0);
    step();
    check_val("beq0_ret", {29'd0, st}, {29'd0, S_FETCH});
    check_val("beq0_pc", {31'd0, pc_en}, 32'd0);

    // BEQ with Z = 1 : taken, zero offset
    begin_instr("beq1", 32'h0A000000, 32'h40000000);
    step();
    check_val("beq1_ex_state", {29'd0, st}, {29'd0, S_EXECUTE});
    check_val("beq1_pc", {27'd0, pc_en, pc_sel, ALU_op}, {27'd0, 2'b11, 3'b000});
    check_val("beq1_imme", imme_data, 32'd0);
    step();

    // B with negative offset (-2 words)
    begin_instr("bneg", 32'hEAFFFFFE, 32'd0);
    step();
    check_val("bneg_imme", imme_data, 32'hFFFFFFF8);
    step();

    // BLT with N=1, V=0 : taken
    begin_instr("blt", 32'hBA000000, 32'h80000000);
    step();
    check_val("blt_state", {29'd0, st}, {29'd0, S_EXECUTE});
    step();

    // BGT with N=1, V=0 : not taken
    begin_instr("bgt", 32'hCA000000, 32'h80000000);
    step();
    check_val("bgt_state", {29'd0, st}, {29'd0, S_FETCH});

    // Condition 1111 never passes
    begin_instr("nv", 32'hF0812002, 32'hF0000000);
    step();
    check_val("nv_state", {29'd0, st}, {29'd0, S_FETCH});

    // RSB (unsupported opcode) is dropped
    begin_instr("rsb", 32'hE0612002, 32'd0);
    step();
    check_val("rsb_state", {29'd0, st}, {29'd0, S_FETCH});
    check_val("rsb_no_wr", {30'd0, w_en1, w_en2}, 32'd0);

    // LDR r3,[r1,#4] : 7 cycles
    begin_instr("ldr", 32'hE5913004, 32'd0);
    step();
    check_val("ldr_ex", {27'd0, addr_en, sel_B, ALU_op}, {27'd0, 2'b11, 3'b000});
    check_val("ldr_imme", imme_data, 32'd4);
    step();
    check_val("ldr_mem_state", {29'd0, st}, {29'd0, S_MEMORY});
    check_val("ldr_mem", {30'd0, ram_rd, ram_w_en}, {30'd0, 2'b10});
    step();
    check_val("ldr_mw_state", {29'd0, st}, {29'd0, S_MEMORY_WAIT});
    step();
    check_val("ldr_wb_state", {29'd0, st}, {29'd0, S_WRITE_BACK});
    check_val("ldr_wb", {25'd0, w_en1, forward_w_data, w_en2, w_addr1}, {25'd0, 3'b110, 4'd3});
    step();

    // STR r3,[r1,#-4] : subtractive address, no register write
    begin_instr("str", 32'hE5013004, 32'd0);
    step();
    check_val("str_ex_alu", {29'd0, ALU_op}, 32'd1);
    step();
    check_val("str_mem", {25'd0, ram_w_en, en_B, sel_A, B_addr}, {25'd0, 3'b111, 4'd3});
    check_val("str_mem_alu", {29'd0, ALU_op}, 32'd0);
    step();
    check_val("str_mw_state", {29'd0, st}, {29'd0, S_MEMORY_WAIT});
    check_val("str_mw_wr", {30'd0, w_en1, w_en2}, 32'd0);
    step();

    // Reset asserted mid-MEMORY
    begin_instr("strrst", 32'hE5013004, 32'd0);
    step();
    step();
    check_val("strrst_mem_w", {31'd0, ram_w_en}, 32'd1);
    rst = 1'b1;
    #1;
    check_val("strrst_state", {29'd0, st}, {29'd0, S_FETCH});
    check_val("strrst_outs", {27'd0, ram_w_en, en_B, pc_en, w_en1, w_en2}, 32'd0);
    check_val("strrst_ir", dut.ir, 32'd0);
    check_val("strrst_baddr", {28'd0, B_addr}, 32'd0);
    @(negedge clk);
    check_val("strrst_hold", {29'd0, st}, {29'd0, S_FETCH});
    rst = 1'b0;

    // Recovery: a fresh ADD sequences normally
    begin_instr("rec", 32'hE0812002, 32'd0);
    step();
    step();
    check_val("rec_wb", {27'd0, w_en2, w_addr2}, {27'd0, 1'b1, 4'd2});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
